// File: rtl/sccb_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the shared i2c_control SCCB master.
// Optional WAIT watchdog is compiled in with `define SCCB_ARB_TIMEOUT_EN.
module sccb_arbiter #(
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        p0_req,
    input  logic        p0_rw,
    input  logic [15:0] p0_addr,
    input  logic [7:0]  p0_wrdata,
    output logic        p0_busy,
    output logic        p0_done,
    output logic [7:0]  p0_rddata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_rw,
    input  logic [15:0] p1_addr,
    input  logic [7:0]  p1_wrdata,
    output logic        p1_busy,
    output logic        p1_done,
    output logic [7:0]  p1_rddata,
    output logic        p1_err,
    output logic        i2c_wrreg_req,
    output logic        i2c_rdreg_req,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_wrdata,
    input  logic [7:0]  i2c_rddata,
    input  logic        i2c_RW_Done,
    input  logic        i2c_ack,
    output logic        timeout_flag,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [2:0]  MAX_R  = 3'(MAX_RETRY);
    localparam logic [23:0] WD_LIM = 24'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       busy_q;
    logic [1:0]       rw_q;
    logic [1:0][15:0] addr_q;
    logic [1:0][7:0]  wrdata_q;
    logic [1:0]       err_q;
    logic [1:0][7:0]  rddata_q;
    logic             owner_q;
    logic             last_grant_q;
    logic [2:0]       retry_q;
    logic [15:0]      bus_addr_q;
    logic [7:0]       bus_wrdata_q;

    logic [1:0]       req_v;
    logic [1:0]       rw_v;
    logic [1:0][15:0] addr_v;
    logic [1:0][7:0]  wrdata_v;
    logic             grant_port;
    logic             retry_now;
    logic             wd_expire;

    assign req_v    = {p1_req, p0_req};
    assign rw_v     = {p1_rw, p0_rw};
    assign addr_v   = {p1_addr, p0_addr};
    assign wrdata_v = {p1_wrdata, p0_wrdata};

    // On a tie the port that did not win the previous tie goes first.
    assign grant_port = (busy_q == 2'b11) ? ~last_grant_q : busy_q[1];
    assign retry_now  = (state_q == WAIT) && i2c_RW_Done && i2c_ack && (retry_q < MAX_R);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (busy_q != 2'b00) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (i2c_RW_Done)    state_d = retry_now ? ISSUE : DONE;
                else if (wd_expire) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 2'b00;
            rw_q         <= 2'b00;
            addr_q       <= '0;
            wrdata_q     <= '0;
            err_q        <= 2'b00;
            rddata_q     <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            retry_q      <= 3'd0;
            bus_addr_q   <= 16'd0;
            bus_wrdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            for (int n = 0; n < 2; n++) begin
                if (req_v[n] && !busy_q[n]) begin
                    busy_q[n]   <= 1'b1;
                    rw_q[n]     <= rw_v[n];
                    addr_q[n]   <= addr_v[n];
                    wrdata_q[n] <= wrdata_v[n];
                end
            end
            if (state_q == IDLE && busy_q != 2'b00) begin
                owner_q      <= grant_port;
                retry_q      <= 3'd0;
                bus_addr_q   <= addr_q[grant_port];
                bus_wrdata_q <= wrdata_q[grant_port];
                if (busy_q == 2'b11) last_grant_q <= grant_port;
            end
            if (retry_now) retry_q <= retry_q + 3'd1;
            // Results are loaded on entry to DONE so they are valid alongside the done strobe.
            if (state_q == WAIT && state_d == DONE) begin
                err_q[owner_q] <= i2c_RW_Done ? i2c_ack : 1'b1;
                if (i2c_RW_Done && rw_q[owner_q]) rddata_q[owner_q] <= i2c_rddata;
            end
            if (state_q == DONE) busy_q[owner_q] <= 1'b0;
        end
    end

`ifdef SCCB_ARB_TIMEOUT_EN
    logic [23:0] wd_q;
    logic        tflag_q;

    assign wd_expire = (state_q == WAIT) && (wd_q == WD_LIM);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wd_q    <= 24'd0;
            tflag_q <= 1'b0;
        end else begin
            if (state_q == ISSUE)                wd_q <= 24'd0;
            else if (state_q == WAIT && !wd_expire) wd_q <= wd_q + 24'd1;
            if (wd_expire && !i2c_RW_Done) tflag_q <= 1'b1;
        end
    end

    assign timeout_flag = tflag_q;
`else
    logic unused_cfg;
    assign unused_cfg   = ^WD_LIM;
    assign wd_expire    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign i2c_wrreg_req = (state_q == ISSUE) && !rw_q[owner_q];
    assign i2c_rdreg_req = (state_q == ISSUE) &&  rw_q[owner_q];
    assign i2c_addr      = bus_addr_q;
    assign i2c_wrdata    = bus_wrdata_q;

    assign p0_busy   = busy_q[0];
    assign p1_busy   = busy_q[1];
    assign p0_done   = (state_q == DONE) && !owner_q;
    assign p1_done   = (state_q == DONE) &&  owner_q;
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];
    assign p0_rddata = rddata_q[0];
    assign p1_rddata = rddata_q[1];
    assign dbg_state = state_q;

endmodule

// File: doc/sccb_arbiter.md
# sccb_arbiter

Two-port arbiter and transaction sequencer that shares the single `i2c_control` SCCB master between requesters: port 0 is the camera register-table writer, port 1 the runtime register access path (exposure or focus tweaks, readback). It latches each port's command, grants the bus round-robin, and issues exactly one write or read request pulse per attempt. It waits for completion, retries on NACK, and returns the result and a done strobe to the owning port. It sits between the camera configuration logic and `i2c_control`, in the `Clk` domain.

## Interface
- `MAX_RETRY`, default 2: extra attempts after a NACK, range 0..7.
- `TIMEOUT_CYC`, default 2_000_000: watchdog limit in WAIT, in cycles (40 ms at 50 MHz). Used only with the macro.
- `Clk` in 1: system clock. All logic is on the rising edge.
- `Rst_n` in 1: asynchronous active-low reset.
- `pN_req` in 1 (N=0,1): one-cycle command strobe. Sampled only when `pN_busy`=0.
- `pN_rw` in 1: 0 = write, 1 = read. Sampled with `pN_req`.
- `pN_addr` in 16: register address. Sampled with `pN_req`.
- `pN_wrdata` in 8: write data. Sampled with `pN_req`.
- `pN_busy` out 1: command latched and not yet completed.
- `pN_done` out 1: one-cycle completion strobe.
- `pN_rddata` out 8: read result. Updated only on a read `pN_done`.
- `pN_err` out 1: result flag for the last command (NACK after all retries, or timeout). Valid at `pN_done` and held until the next `pN_done`.
- `i2c_wrreg_req` out 1: write request pulse to `i2c_control`.
- `i2c_rdreg_req` out 1: read request pulse to `i2c_control`.
- `i2c_addr` out 16: address to `i2c_control`.
- `i2c_wrdata` out 8: write data to `i2c_control`.
- `i2c_rddata` in 8: read data from `i2c_control`.
- `i2c_RW_Done` in 1: transaction-complete pulse from `i2c_control`.
- `i2c_ack` in 1: 1 = slave did not acknowledge. Valid with `i2c_RW_Done`.
- `timeout_flag` out 1: sticky watchdog indication. Cleared only by reset.

## Operation
- **Command latch.** Each port has its own pending register set (rw, addr, wrdata) and a `busy` bit.
  - `pN_req`=1 at an edge where `pN_busy`=0 loads the registers and sets `busy`.
  - A request while `busy`=1 is ignored, including in the `pN_done` cycle.
- **State machine** states: IDLE, ISSUE, WAIT, DONE.
  - **IDLE**
    - If any port is busy and unserved, latch `owner` and go to ISSUE.
    - Both busy: grant the port that is not `last_grant`, then update `last_grant`.
    - Clear the retry counter on grant.
  - **ISSUE**
    - Assert `i2c_wrreg_req` (rw=0) or `i2c_rdreg_req` (rw=1) for exactly this one cycle.
    - Go to WAIT.
  - **WAIT** exits on `i2c_RW_Done`:
    - `i2c_ack`=0: go to DONE with err=0.
    - `i2c_ack`=1 and retry count < `MAX_RETRY`: increment the retry count and go to ISSUE.
    - `i2c_ack`=1 and retries exhausted: go to DONE with err=1.
  - **DONE** (one cycle)
    - Assert `p[owner]_done`.
    - Load `p[owner]_err`. Load `p[owner]_rddata` from `i2c_rddata` captured at the completing `i2c_RW_Done`, reads only.
    - Clear `p[owner]_busy` on the edge ending DONE.
    - Go to IDLE.
- **Bus outputs.** `i2c_addr` and `i2c_wrdata` are registered. They follow the owner's pending registers and are stable from ISSUE through the end of WAIT.
- **Retry count.** Width is 3 bits. Wrap is impossible because `MAX_RETRY` ≤ 7.

## Timing
- **Reset values.** All outputs are 0 and state is IDLE. `last_grant`=1, so port 0 wins the first tie.
- **Reset mid-transaction.** All pending commands are dropped without a `done`. `i2c_control` shares `Rst_n`.
- **Request to bus.** `pN_req` at edge k: `busy`=1 after k. IDLE grants at k+1. ISSUE pulse is in cycle k+1..k+2. Minimum latency is 2 cycles.
- **Completion.** `i2c_RW_Done` at edge j: DONE in cycle j..j+1. `pN_done` is 1 cycle after `RW_Done`, and `busy` drops at j+1.
- **Back-to-back.** The earliest next ISSUE for the other port is 1 cycle after DONE (IDLE then ISSUE).
- **Simultaneous `p0_req`/`p1_req`.** Both are latched. Service follows round-robin order.
- **`i2c_RW_Done` outside WAIT** is ignored.

## Configuration
- `SCCB_ARB_TIMEOUT_EN`
  - **Defined:** a 24-bit watchdog counts cycles in WAIT and clears on each ISSUE.
    - On reaching `TIMEOUT_CYC` with no `i2c_RW_Done`: go to DONE with err=1, set `timeout_flag`, and skip any retries.
    - `i2c_RW_Done` in the same cycle as expiry: `RW_Done` wins.
  - **Undefined:** no counter. WAIT holds until `i2c_RW_Done`, and `timeout_flag` is tied to 0.

## Test plan
- Port 0 write, addr 16'h3008, data 8'h82, `i2c_ack`=0: `i2c_wrreg_req` pulses once 2 cycles after req, and `p0_done`=1 one cycle after `RW_Done` with `p0_err`=0.
- Port 1 read, addr 16'h300A, model returns 8'h56: `i2c_rdreg_req` pulses once, and `p1_rddata`=8'h56, `p1_err`=0 at `p1_done`.
- Simultaneous `p0_req`/`p1_req` twice in a row: grant order is p0, p1, then p1, p0. `i2c_addr` stays stable throughout each WAIT.
- `i2c_ack`=1 on every attempt, `MAX_RETRY`=2: exactly 3 request pulses, then `p0_done` with `p0_err`=1. A second `p0_req` while busy is ignored.
- With `SCCB_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=100, model never returns `RW_Done`: `done`/`err`=1 after 100 WAIT cycles and `timeout_flag`=1. Assert `Rst_n` mid-WAIT: all outputs go to 0, with no `done`.
